// File: rtl/stim_seq_pkg.sv
// Shared state encoding and {value,hold} field helpers for the stimulus sequencer.
package stim_seq_pkg;

    localparam logic [1:0] ENC_IDLE = 2'd0;
    localparam logic [1:0] ENC_PRE  = 2'd1;
    localparam logic [1:0] ENC_HOLD = 2'd2;
    localparam logic [1:0] ENC_DONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = ENC_IDLE,
        ST_PRE  = ENC_PRE,
        ST_HOLD = ENC_HOLD,
        ST_DONE = ENC_DONE
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Table words are {value, hold}; callers truncate to their own widths (word <= 64 bits).
    function automatic logic [63:0] step_value(input logic [63:0] word, input int dly_w);
        return word >> dly_w;
    endfunction

    function automatic logic [63:0] step_hold(input logic [63:0] word, input int dly_w);
        return word & ((64'd1 << dly_w) - 64'd1);
    endfunction

endpackage

// File: rtl/stim_step_ram.sv
// Step table storage: synchronous write, combinational read.
// Latency: write visible to reads after the writing edge; read is same-cycle.
// Backpressure: none; the caller gates writes.
module stim_step_ram #(
    parameter int W     = 22,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stim_sequencer.sv
// Plays a {value,hold} step table onto STIM after start and a START_DLY lead-in; one-shot or looping.
// Latency: step 0 appears START_DLY+1 edges after start acceptance; steps follow back to back.
// Backpressure: start and table writes are ignored while busy; abort always wins.
module stim_sequencer
    import stim_seq_pkg::*;
#(
    parameter int                OUT_W     = 6,
    parameter int                DEPTH     = 8,
    parameter int                DLY_W     = 16,
    parameter int                START_DLY = 15,
    parameter logic [OUT_W-1:0]  IDLE_VAL  = '0
) (
    input  logic                      CLK50MHZ,
    input  logic                      RST,
    input  logic                      wr_en,
    input  logic [clog2(DEPTH)-1:0]   wr_addr,
    input  logic [OUT_W+DLY_W-1:0]    wr_data,
    input  logic [clog2(DEPTH):0]     num_steps,
    input  logic                      loop_en,
    input  logic                      start,
    input  logic                      abort,
    output logic [OUT_W-1:0]          STIM,
    output logic [clog2(DEPTH)-1:0]   step_idx,
    output logic                      busy,
    output logic                      done
);

    localparam int              AW        = clog2(DEPTH);
    localparam int              WORD_W    = OUT_W + DLY_W;
    localparam logic [AW:0]     DEPTH_N   = (AW+1)'(DEPTH);
    localparam logic [DLY_W-1:0] LEAD_INIT = DLY_W'(START_DLY);

    state_t             state;
    logic [DLY_W-1:0]   lead_cnt;
    logic [DLY_W-1:0]   hold_cnt;
    logic [AW-1:0]      idx;
    logic [AW:0]        num_q;
    logic               loop_q;
    logic [OUT_W-1:0]   stim_q;
    logic               busy_q;
    logic               done_q;

    logic               idle_like;
    logic               can_start;
    logic               wr_ok;
    logic [AW:0]        num_clamped;
    logic [AW-1:0]      last_idx;
    logic               is_last;
    logic [AW-1:0]      next_idx;
    logic [AW-1:0]      rd_addr;
    logic [WORD_W-1:0]  rd_word;
    logic [OUT_W-1:0]   rd_value;
    logic [DLY_W-1:0]   rd_hold;
    logic [DLY_W-1:0]   hold_load;

    assign idle_like   = (state == ST_IDLE) || (state == ST_DONE);
    assign can_start   = idle_like && start && !abort;
    assign wr_ok       = wr_en && idle_like;
    assign num_clamped = (num_steps > DEPTH_N) ? DEPTH_N : num_steps;
    assign last_idx    = AW'(num_q - 1'b1);
    assign is_last     = (idx == last_idx);
    assign next_idx    = is_last ? '0 : idx + 1'b1;

    // The read port always presents the step that would be loaded at the next edge.
    assign rd_addr   = (state == ST_HOLD) ? next_idx : '0;
    assign rd_value  = OUT_W'(step_value(64'(rd_word), DLY_W));
    assign rd_hold   = DLY_W'(step_hold(64'(rd_word), DLY_W));
    assign hold_load = (rd_hold == '0) ? '0 : rd_hold - 1'b1;

    stim_step_ram #(
        .W     (WORD_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (CLK50MHZ),
        .we    (wr_ok),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (rd_addr),
        .rdata (rd_word)
    );

    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            state    <= ST_IDLE;
            lead_cnt <= '0;
            hold_cnt <= '0;
            idx      <= '0;
            num_q    <= '0;
            loop_q   <= 1'b0;
            stim_q   <= IDLE_VAL;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (abort && (state != ST_IDLE)) begin
            state    <= ST_IDLE;
            lead_cnt <= '0;
            hold_cnt <= '0;
            idx      <= '0;
            stim_q   <= IDLE_VAL;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (can_start) begin
                        num_q  <= num_clamped;
                        loop_q <= loop_en;
                        idx    <= '0;
                        if (num_clamped == '0) begin
                            state  <= ST_DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            state    <= ST_PRE;
                            lead_cnt <= LEAD_INIT;
                            busy_q   <= 1'b1;
                            done_q   <= 1'b0;
                        end
                    end
                end
                ST_PRE: begin
                    if (lead_cnt == '0) begin
                        state    <= ST_HOLD;
                        stim_q   <= rd_value;
                        hold_cnt <= hold_load;
                        idx      <= '0;
                    end else begin
                        lead_cnt <= lead_cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end else if (is_last && !loop_q) begin
                        state  <= ST_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        idx      <= next_idx;
                        stim_q   <= rd_value;
                        hold_cnt <= hold_load;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign STIM     = stim_q;
    assign step_idx = idx;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_stim_sequencer.sv
// Scoreboard bench for stim_sequencer: expected per-cycle outputs are queued at start, compared each negedge.
module tb_stim_sequencer;

    typedef struct packed {
        logic [5:0] stim;
        logic       busy;
        logic       done;
        logic [2:0] idx;
    } exp_t;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [21:0] wr_data = '0;
    logic [3:0]  num_steps = '0;
    logic        loop_en = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [5:0]  STIM, stim0;
    logic [2:0]  step_idx, idx0;
    logic        busy, busy0, done, done0;

    exp_t        exp_q[$];
    exp_t        e;
    logic [5:0]  tbl_val [8];
    logic [15:0] tbl_hold[8];
    int          total = 0;
    int          bad = 0;

    always #10 clk = ~clk;

    stim_sequencer dut (
        .CLK50MHZ(clk), .RST(RST), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .num_steps(num_steps), .loop_en(loop_en), .start(start), .abort(abort),
        .STIM(STIM), .step_idx(step_idx), .busy(busy), .done(done)
    );

    stim_sequencer #(.START_DLY(0)) dut0 (
        .CLK50MHZ(clk), .RST(RST), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .num_steps(num_steps), .loop_en(loop_en), .start(start), .abort(abort),
        .STIM(stim0), .step_idx(idx0), .busy(busy0), .done(done0)
    );

    task automatic push_exp(input logic [5:0] v, input logic b, input logic d, input int i);
        exp_t x;
        x.stim = v;
        x.busy = b;
        x.done = d;
        x.idx  = 3'(i);
        exp_q.push_back(x);
    endtask

    // Reference timeline: observation n is sampled after the n-th edge following start acceptance.
    task automatic push_run(input int num, input bit lp, input int sdly, input int n_obs,
                            input logic [5:0] prev);
        int cnt;
        int i;
        int h;
        cnt = 0;
        if (num > 8) num = 8;
        if (num == 0) begin
            while (cnt < n_obs) begin push_exp(prev, 1'b0, 1'b1, 0); cnt++; end
            return;
        end
        for (int p = 0; p <= sdly && cnt < n_obs; p++) begin
            push_exp(prev, 1'b1, 1'b0, 0);
            cnt++;
        end
        i = 0;
        while (cnt < n_obs) begin
            h = (tbl_hold[i] == 16'd0) ? 1 : int'(tbl_hold[i]);
            for (int c = 0; c < h && cnt < n_obs; c++) begin
                push_exp(tbl_val[i], 1'b1, 1'b0, i);
                cnt++;
            end
            if (i == num - 1) begin
                if (lp) i = 0;
                else while (cnt < n_obs) begin push_exp(tbl_val[i], 1'b0, 1'b1, i); cnt++; end
            end else begin
                i++;
            end
        end
    endtask

    task automatic write_tbl(input int n);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_addr = 3'(i);
            wr_data = {tbl_val[i], tbl_hold[i]};
            @(negedge clk);
            wr_en = 1'b0;
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        @(negedge clk);
        @(negedge clk);
        RST = 1'b0;
    endtask

    task automatic do_start(input int num, input bit lp);
        num_steps = 4'(num);
        loop_en   = lp;
        start     = 1'b1;
    endtask

    task automatic set_short_table();
        tbl_val[0] = 6'h11; tbl_hold[0] = 16'd2;
        tbl_val[1] = 6'h12; tbl_hold[1] = 16'd3;
        tbl_val[2] = 6'h13; tbl_hold[2] = 16'd1;
        tbl_val[3] = 6'h14; tbl_hold[3] = 16'd6;
        tbl_val[4] = 6'h15; tbl_hold[4] = 16'd2;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({STIM, busy, done, step_idx} !== 11'd0) begin
            bad++;
            $display("FAIL reset got stim=%h busy=%b done=%b idx=%0d want all zero", STIM, busy, done, step_idx);
        end
        total++;
        if ({stim0, busy0, done0, idx0} !== 11'd0) begin
            bad++;
            $display("FAIL reset_dly0 got stim=%h busy=%b done=%b idx=%0d want all zero", stim0, busy0, done0, idx0);
        end
        RST = 1'b0;
    endtask

    task automatic test_board();
        int n;
        tbl_val[0] = 6'h02; tbl_hold[0] = 16'd12;
        tbl_val[1] = 6'h00; tbl_hold[1] = 16'd190;
        tbl_val[2] = 6'h02; tbl_hold[2] = 16'd12;
        tbl_val[3] = 6'h00; tbl_hold[3] = 16'd190;
        tbl_val[4] = 6'h04; tbl_hold[4] = 16'd100;
        tbl_val[5] = 6'h00; tbl_hold[5] = 16'd75;
        write_tbl(6);
        do_start(6, 1'b0);
        push_run(6, 1'b0, 15, 16 + 579 + 4, 6'h00);
        n = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            start = 1'b0;
            e = exp_q.pop_front();
            total++;
            if ({STIM, busy, done, step_idx} !== e) begin
                bad++;
                $display("FAIL board n=%0d got stim=%h busy=%b done=%b idx=%0d want stim=%h busy=%b done=%b idx=%0d",
                         n, STIM, busy, done, step_idx, e.stim, e.busy, e.done, e.idx);
            end
            n++;
        end
    endtask

    task automatic test_loop();
        int n;
        do_reset();
        tbl_val[0] = 6'h01; tbl_hold[0] = 16'd3;
        tbl_val[1] = 6'h02; tbl_hold[1] = 16'd0;
        write_tbl(2);
        do_start(2, 1'b1);
        push_run(2, 1'b1, 15, 16 + 20, 6'h00);
        n = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            start = 1'b0;
            e = exp_q.pop_front();
            total++;
            if ({STIM, busy, done, step_idx} !== e) begin
                bad++;
                $display("FAIL loop n=%0d got stim=%h busy=%b done=%b idx=%0d want stim=%h busy=%b done=%b idx=%0d",
                         n, STIM, busy, done, step_idx, e.stim, e.busy, e.done, e.idx);
            end
            n++;
        end
    endtask

    task automatic test_abort();
        int n;
        do_reset();
        set_short_table();
        write_tbl(5);
        do_start(5, 1'b0);
        push_run(5, 1'b0, 15, 25, 6'h00);
        n = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            start = 1'b0;
            e = exp_q.pop_front();
            total++;
            if ({STIM, busy, done, step_idx} !== e) begin
                bad++;
                $display("FAIL abort_pre n=%0d got stim=%h busy=%b done=%b idx=%0d want stim=%h busy=%b done=%b idx=%0d",
                         n, STIM, busy, done, step_idx, e.stim, e.busy, e.done, e.idx);
            end
            n++;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total++;
        if ({STIM, busy, done, step_idx} !== 11'd0) begin
            bad++;
            $display("FAIL abort_idle got stim=%h busy=%b done=%b idx=%0d want all zero", STIM, busy, done, step_idx);
        end
        do_start(5, 1'b0);
        push_run(5, 1'b0, 15, 16 + 14 + 3, 6'h00);
        n = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            start = 1'b0;
            e = exp_q.pop_front();
            total++;
            if ({STIM, busy, done, step_idx} !== e) begin
                bad++;
                $display("FAIL abort_replay n=%0d got stim=%h busy=%b done=%b idx=%0d want stim=%h busy=%b done=%b idx=%0d",
                         n, STIM, busy, done, step_idx, e.stim, e.busy, e.done, e.idx);
            end
            n++;
        end
    endtask

    task automatic test_zero_cases();
        int n;
        do_reset();
        do_start(0, 1'b0);
        push_run(0, 1'b0, 15, 3, 6'h00);
        n = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            start = 1'b0;
            e = exp_q.pop_front();
            total++;
            if ({STIM, busy, done, step_idx} !== e) begin
                bad++;
                $display("FAIL num_zero n=%0d got stim=%h busy=%b done=%b idx=%0d want stim=%h busy=%b done=%b idx=%0d",
                         n, STIM, busy, done, step_idx, e.stim, e.busy, e.done, e.idx);
            end
            n++;
        end
        do_reset();
        do_start(2, 1'b0);
        push_run(2, 1'b0, 0, 8, 6'h00);
        n = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            start = 1'b0;
            e = exp_q.pop_front();
            total++;
            if ({stim0, busy0, done0, idx0} !== e) begin
                bad++;
                $display("FAIL dly0 n=%0d got stim=%h busy=%b done=%b idx=%0d want stim=%h busy=%b done=%b idx=%0d",
                         n, stim0, busy0, done0, idx0, e.stim, e.busy, e.done, e.idx);
            end
            n++;
        end
    endtask

    task automatic test_busy_ignore();
        int n;
        do_reset();
        do_start(5, 1'b0);
        push_run(5, 1'b0, 15, 33, 6'h00);
        n = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            start = 1'b0;
            wr_en = 1'b0;
            e = exp_q.pop_front();
            total++;
            if ({STIM, busy, done, step_idx} !== e) begin
                bad++;
                $display("FAIL busy_ignore n=%0d got stim=%h busy=%b done=%b idx=%0d want stim=%h busy=%b done=%b idx=%0d",
                         n, STIM, busy, done, step_idx, e.stim, e.busy, e.done, e.idx);
            end
            if (n == 20) begin
                wr_en     = 1'b1;
                wr_addr   = 3'd0;
                wr_data   = {6'h3f, 16'd9};
                num_steps = 4'd1;
                start     = 1'b1;
            end
            n++;
        end
        // Restart from DONE: PRE keeps the last value, step 0 must still be the original entry.
        do_start(5, 1'b0);
        push_run(5, 1'b0, 15, 18, 6'h15);
        n = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            start = 1'b0;
            e = exp_q.pop_front();
            total++;
            if ({STIM, busy, done, step_idx} !== e) begin
                bad++;
                $display("FAIL table_kept n=%0d got stim=%h busy=%b done=%b idx=%0d want stim=%h busy=%b done=%b idx=%0d",
                         n, STIM, busy, done, step_idx, e.stim, e.busy, e.done, e.idx);
            end
            n++;
        end
        abort = 1'b1;
        start = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            abort = 1'b0;
            start = 1'b0;
            total++;
            if ({STIM, busy, done, step_idx} !== 11'd0) begin
                bad++;
                $display("FAIL abort_start k=%0d got stim=%h busy=%b done=%b idx=%0d want all zero",
                         k, STIM, busy, done, step_idx);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        for (int r = 0; r < 2; r++) begin
            do_start(5, 1'b0);
            push_run(5, 1'b0, 15, (r == 0) ? 5 : 20, 6'h00);
            n = 0;
            while (exp_q.size() > 0) begin
                @(negedge clk);
                start = 1'b0;
                e = exp_q.pop_front();
                total++;
                if ({STIM, busy, done, step_idx} !== e) begin
                    bad++;
                    $display("FAIL rst_run r=%0d n=%0d got stim=%h busy=%b done=%b idx=%0d want stim=%h busy=%b done=%b idx=%0d",
                             r, n, STIM, busy, done, step_idx, e.stim, e.busy, e.done, e.idx);
                end
                n++;
            end
            RST = 1'b1;
            @(negedge clk);
            RST = 1'b0;
            total++;
            if ({STIM, busy, done, step_idx} !== 11'd0) begin
                bad++;
                $display("FAIL rst_mid r=%0d got stim=%h busy=%b done=%b idx=%0d want all zero",
                         r, STIM, busy, done, step_idx);
            end
        end
        do_start(5, 1'b0);
        push_run(5, 1'b0, 15, 33, 6'h00);
        n = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            start = 1'b0;
            e = exp_q.pop_front();
            total++;
            if ({STIM, busy, done, step_idx} !== e) begin
                bad++;
                $display("FAIL rst_retain n=%0d got stim=%h busy=%b done=%b idx=%0d want stim=%h busy=%b done=%b idx=%0d",
                         n, STIM, busy, done, step_idx, e.stim, e.busy, e.done, e.idx);
            end
            n++;
        end
    endtask

    initial begin
        test_reset();
        test_board();
        test_loop();
        test_abort();
        test_zero_cases();
        test_busy_ignore();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
